dm_stream_out: RTL
==================

# dm_stream_out

Read-side streaming engine for a PE data memory. On a start command it issues a burst of sequential reads on one BRAM read port, absorbs the BRAM's fixed read latency, and presents the words as a valid/ready stream with a last marker. It sits between a PE's data memory read port (shift-out / result drain path) and the downstream consumer: the next PE's shift-in, or the array's output collector. It also handles back-pressure without losing or duplicating words.

## Interface
Parameters:
- DATA_WIDTH, 32, word width (two packed 16-bit values)
- ADDR_WIDTH, 8, data memory address width (256 words)
- RD_LAT, 2, BRAM read latency in cycles from `rd_en`/`rd_addr` to `rd_data`
- FIFO_DEPTH, 4, output buffer depth; must be at least RD_LAT+2

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle command pulse; ignored while `busy`.
- base_addr, input, ADDR_WIDTH: first read address, sampled with `start`.
- len, input, ADDR_WIDTH+1: number of words, 0..256, sampled with `start`.
- busy, output, 1: high from the cycle after an accepted `start` until `done`.
- done, output, 1: one-cycle pulse after the last beat handshakes.
- rd_en, output, 1: BRAM read enable.
- rd_addr, output, ADDR_WIDTH: BRAM read address.
- rd_data, input, DATA_WIDTH: BRAM read data, valid RD_LAT cycles after `rd_en`.
- m_tdata, output, DATA_WIDTH: stream data.
- m_tvalid, output, 1: stream valid.
- m_tready, input, 1: stream ready.
- m_tlast, output, 1: marks the final word of the burst.

## Operation
- FSM states:
  - IDLE: waits for `start`.
    - Accepted `start` with `len`>0: latch `base_addr` into the address counter and `len` into the issue counter and beat counter, then go to RUN.
    - Accepted `start` with `len`=0: go to DONE, with no reads and no beats.
  - RUN: issues reads until the issue counter reaches 0, then goes to DRAIN.
  - DRAIN: waits until the beat counter reaches 0, i.e. all beats have handshaked, then goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- `busy` = state != IDLE.
- Read issue:
  - In RUN, `rd_en`=1 when credits allow: outstanding < FIFO_DEPTH.
    - outstanding = (reads in flight in the RD_LAT shift register) + (FIFO occupancy) − (pop this cycle).
  - Each issued read increments `rd_addr` modulo 2^ADDR_WIDTH (255→0 wraps) and decrements the issue counter.
- Return path:
  - A RD_LAT-deep valid shift register tracks issued reads.
  - When its tail is 1, `rd_data` is written into the FIFO.
  - The credit rule guarantees the FIFO never overflows; an overflow is a design error, flagged by an assertion in simulation.
- Stream:
  - `m_tvalid` = FIFO not empty; `m_tdata` = FIFO head.
  - Pop on `m_tvalid & m_tready`.
  - `m_tdata` must stay stable while `m_tvalid & !m_tready`.
  - `m_tlast` = `m_tvalid` and beat counter == 1.
- The beat counter decrements on each handshake.
- A push and a pop of the FIFO in the same cycle are both honoured; occupancy is unchanged.
- `start` while busy: ignored, with no effect on the counters.
- Reset:
  - Asynchronous `rst_n` low at any time, including mid-burst, forces IDLE, empties the FIFO and clears the in-flight register.
  - All outputs go to 0: `busy`, `done`, `rd_en`, `rd_addr`, `m_tvalid`, `m_tlast`, `m_tdata`.
  - After release, no stale `rd_data` is captured.

## Timing
- `start` sampled at edge E0.
- RUN from the cycle after E0.
- First `rd_en` in cycle 1 after E0.
- Data captured at the end of cycle 1+RD_LAT.
- First `m_tvalid` in cycle 2+RD_LAT after E0 (cycle 4 at defaults).
- With `m_tready` held 1: one beat per cycle, no bubbles, with the last beat in cycle 2+RD_LAT+len−1.
- `done` fires the cycle after the last handshake; `busy` drops in the same cycle `done` falls.
- `len`=0: `done` in cycle 1 after E0, `busy` high for that one cycle.
- `m_tready` low: issue stalls once outstanding reaches FIFO_DEPTH. Reads already in flight still land in the FIFO, and issue resumes the cycle after a pop frees a credit.

## Test plan
- Base 0x20, len 8, `m_tready`=1, memory preloaded with addr+0x1000 → 8 beats 0x1020..0x1027 in consecutive cycles, first beat in cycle 4, `m_tlast` on 0x1027, `done` one cycle later.
- Base 0xFE, len 4 → reads 0xFE, 0xFF, 0x00, 0x01; beats carry the data from those addresses in that order.
- Base 0x40, len 16, `m_tready` toggling 1-0-0-1 pseudo-randomly → all 16 words delivered exactly once in order. `m_tdata` is stable during stalls, and FIFO occupancy never exceeds 4.
- `m_tready`=0 for 20 cycles after start with len 10 → exactly 4 reads issued, then `rd_en` stays 0. Releasing `m_tready` delivers all 10 words.
- `len`=0 → no `rd_en` and no `m_tvalid`; `done` one cycle after `start`. A second `start` pulsed mid-burst of len 8 is ignored: exactly 8 beats are delivered.
- `rst_n` asserted after the 3rd beat of a len-8 burst → all outputs 0 immediately. A new start with base 0x00, len 2 delivers exactly 2 correct beats with no leftover data.

Source files
------------

// File: rtl/dm_stream_out.sv
// Read-side streaming engine: bursts sequential BRAM reads, absorbs the fixed read latency
// and presents the words as a valid/ready stream with a last marker.
module dm_stream_out #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o
);

  localparam int unsigned LenW = ADDR_WIDTH + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  localparam logic [LenW-1:0]       LenOne  = LenW'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [PtrW-1:0]       PtrOne  = PtrW'(1);
  localparam logic [PtrW-1:0]       PtrLast = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CntW-1:0]       CntOne  = CntW'(1);
  localparam logic [CntW-1:0]       CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LenW-1:0]       issue_q;
  logic [LenW-1:0]       beat_q;

  logic [RD_LAT-1:0]     vld_d, vld_q;
  logic [PtrW-1:0]       wptr_d, wptr_q, rptr_d, rptr_q;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic        fifo_empty, push, pop;
  int unsigned outstanding;

  assign fifo_empty = (cnt_q == '0);
  assign push       = vld_q[RD_LAT-1];
  assign pop        = !fifo_empty && m_tready_i;

  // Credits cover every read that has been issued but not yet popped, so the FIFO never overflows.
  always_comb begin
    outstanding = 32'(cnt_q);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding += 32'(vld_q[i]);
    end
    if (pop) begin
      outstanding -= 1;
    end
    rd_en_o = (state_q == StRun) && (issue_q != '0) && (outstanding < FIFO_DEPTH);
  end

  always_comb begin
    vld_d[0] = rd_en_o;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrOne;
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrOne;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= rd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      issue_q <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i == '0) begin
              state_q <= StDone;
            end else begin
              addr_q  <= base_addr_i;
              issue_q <= len_i;
              beat_q  <= len_i;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (rd_en_o) begin
            addr_q  <= addr_q + AddrOne;
            issue_q <= issue_q - LenOne;
            if (issue_q == LenOne) begin
              state_q <= StDrain;
            end
          end
          if (pop) begin
            beat_q <= beat_q - LenOne;
          end
        end
        StDrain: begin
          if (pop) begin
            beat_q <= beat_q - LenOne;
            if (beat_q == LenOne) begin
              state_q <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);
  assign rd_addr_o  = addr_q;
  assign m_tvalid_o = !fifo_empty;
  assign m_tdata_o  = fifo_empty ? '0 : mem_q[rptr_q];
  assign m_tlast_o  = !fifo_empty && (beat_q == LenOne);

  fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CntFull)));

endmodule
